// File: rtl/fnv1a_pkg.sv
// Shared types and constants for the FNV-1a 32-bit hash controller.
package fnv1a_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_FEED  = 3'd2,
        ST_XOR   = 3'd3,
        ST_MUL   = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    localparam logic [31:0] OFFSET_BASIS = 32'h811C9DC5;
    localparam logic [31:0] FNV_PRIME    = 32'h01000193;

    localparam logic [7:0] CMD_RESET = 8'h01;
    localparam logic [7:0] CMD_FEED  = 8'h02;
    localparam logic [7:0] CMD_LATCH = 8'h03;

    // Index of the final shift-add term of the prime multiply.
    localparam logic [2:0] MUL_LAST = 3'd5;

    // FNV prime 0x01000193 = 2^24 + 2^8 + 2^7 + 2^4 + 2^1 + 2^0.
    function automatic logic [4:0] mul_shift(input logic [2:0] idx);
        logic [4:0] sh;
        case (idx)
            3'd0:    sh = 5'd24;
            3'd1:    sh = 5'd8;
            3'd2:    sh = 5'd7;
            3'd3:    sh = 5'd4;
            3'd4:    sh = 5'd1;
            3'd5:    sh = 5'd0;
            default: sh = 5'd0;
        endcase
        return sh;
    endfunction

    // Select byte idx of a word, idx 0 being the most significant byte.
    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            2'd3:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/fnv1a_mul_step.sv
// Six-cycle shift-add multiply of a 32-bit value by the FNV prime (mod 2^32).
// A start pulse loads acc_in; done is high in the sixth accumulate cycle with
// the final product on prod in that same cycle.
module fnv1a_mul_step
    import fnv1a_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] acc_in,
    output logic        done,
    output logic [31:0] prod
);

    logic [31:0] acc_r;
    logic [31:0] sum_r;
    logic [2:0]  cnt_r;
    logic        run_r;
    logic [31:0] term_s;

    // Current shift-add term selected by the term counter.
    always_comb begin
        term_s = acc_r << mul_shift(cnt_r);
    end

    // Load operand on start, then accumulate one term per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= 32'h0000_0000;
            sum_r <= 32'h0000_0000;
            cnt_r <= 3'd0;
            run_r <= 1'b0;
        end else if (start) begin
            acc_r <= acc_in;
            sum_r <= 32'h0000_0000;
            cnt_r <= 3'd0;
            run_r <= 1'b1;
        end else if (run_r) begin
            sum_r <= sum_r + term_s;
            if (cnt_r == MUL_LAST) begin
                cnt_r <= 3'd0;
                run_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r + 3'd1;
            end
        end else begin
            sum_r <= sum_r;
        end
    end

    // Final product is presented during the last term cycle.
    always_comb begin
        done = run_r && (cnt_r == MUL_LAST);
        prod = sum_r + term_s;
    end

endmodule

// File: rtl/fnv1a_hash_ctrl.sv
// FNV-1a 32-bit hash controller: decodes I2C write commands, sequences the
// XOR/multiply step per data byte and serves the latched digest MSB-first.
module fnv1a_hash_ctrl
    import fnv1a_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_start,
    input  logic        rx_stop,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        tx_req,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        cmd_err,
    output logic [31:0] hash_q
);

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  byte_r;
    logic [31:0] hash_r;
    logic [31:0] readback_r;
    logic [1:0]  rd_ptr_r;
    logic [7:0]  tx_data_r;
    logic        cmd_err_r;
    logic        stop_pend_r;
    logic        start_pend_r;

    logic        accept_s;
    logic        cmd_accept_s;
    logic        in_step_s;
    logic        start_now_s;
    logic        stop_now_s;
    logic        mul_start_s;
    logic        mul_done_s;
    logic [31:0] mul_prod_s;
    logic [31:0] acc_in_s;

    // Handshake and step qualifiers derived from the current state.
    always_comb begin
        accept_s     = rx_valid && rx_ready;
        cmd_accept_s = accept_s && (state_r == ST_CMD);
        in_step_s    = (state_r == ST_XOR) || (state_r == ST_MUL)
                       || ((state_r == ST_FEED) && accept_s);
        // The most recent bus event wins when a step finishes.
        start_now_s  = rx_start || (start_pend_r && !rx_stop);
        stop_now_s   = rx_stop || (stop_pend_r && !rx_start);
        mul_start_s  = (state_r == ST_XOR);
        acc_in_s     = hash_r ^ {24'h00_0000, byte_r};
    end

    fnv1a_mul_step u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start_s),
        .acc_in (acc_in_s),
        .done   (mul_done_s),
        .prod   (mul_prod_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; a hash step is never interrupted.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rx_start) state_s = ST_CMD;
                else          state_s = ST_IDLE;
            end
            ST_CMD: begin
                if (rx_start) begin
                    state_s = ST_CMD;
                end else if (accept_s) begin
                    case (rx_data)
                        CMD_FEED: state_s = ST_FEED;
                        default:  state_s = ST_DRAIN;
                    endcase
                end else if (rx_stop) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_CMD;
                end
            end
            ST_FEED: begin
                if (accept_s)      state_s = ST_XOR;
                else if (rx_start) state_s = ST_CMD;
                else if (rx_stop)  state_s = ST_IDLE;
                else               state_s = ST_FEED;
            end
            ST_XOR: begin
                state_s = ST_MUL;
            end
            ST_MUL: begin
                if (!mul_done_s)      state_s = ST_MUL;
                else if (start_now_s) state_s = ST_CMD;
                else if (stop_now_s)  state_s = ST_IDLE;
                else                  state_s = ST_FEED;
            end
            ST_DRAIN: begin
                if (rx_start)     state_s = ST_CMD;
                else if (rx_stop) state_s = ST_IDLE;
                else              state_s = ST_DRAIN;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs decoded from the state register only.
    always_comb begin
        case (state_r)
            ST_CMD, ST_FEED, ST_DRAIN: begin
                rx_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_XOR, ST_MUL: begin
                rx_ready = 1'b0;
                busy     = 1'b1;
            end
            default: begin
                rx_ready = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    // Remember bus START/STOP events that arrive while a byte is being hashed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_pend_r <= 1'b0;
            stop_pend_r  <= 1'b0;
        end else if (!in_step_s) begin
            start_pend_r <= 1'b0;
            stop_pend_r  <= 1'b0;
        end else if (rx_start) begin
            start_pend_r <= 1'b1;
            stop_pend_r  <= 1'b0;
        end else if (rx_stop) begin
            stop_pend_r  <= 1'b1;
            start_pend_r <= 1'b0;
        end else begin
            start_pend_r <= start_pend_r;
            stop_pend_r  <= stop_pend_r;
        end
    end

    // Running hash, captured data byte and sticky command error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hash_r    <= OFFSET_BASIS;
            byte_r    <= 8'h00;
            cmd_err_r <= 1'b0;
        end else begin
            if (cmd_accept_s && (rx_data == CMD_RESET)) begin
                hash_r <= OFFSET_BASIS;
            end else if ((state_r == ST_MUL) && mul_done_s) begin
                hash_r <= mul_prod_s;
            end else begin
                hash_r <= hash_r;
            end
            if ((state_r == ST_FEED) && accept_s) begin
                byte_r <= rx_data;
            end else begin
                byte_r <= byte_r;
            end
            if (cmd_accept_s && (rx_data != CMD_RESET) && (rx_data != CMD_FEED)
                && (rx_data != CMD_LATCH)) begin
                cmd_err_r <= 1'b1;
            end else begin
                cmd_err_r <= cmd_err_r;
            end
        end
    end

    // Readback register and read pointer; a same-cycle read sees the old digest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readback_r <= OFFSET_BASIS;
            rd_ptr_r   <= 2'd0;
            tx_data_r  <= 8'h00;
        end else begin
            if (tx_req) begin
                tx_data_r <= byte_sel(readback_r, rd_ptr_r);
                rd_ptr_r  <= rd_ptr_r + 2'd1;
            end else begin
                tx_data_r <= tx_data_r;
            end
            if (cmd_accept_s && (rx_data == CMD_LATCH)) begin
                readback_r <= hash_r;
                rd_ptr_r   <= 2'd0;
            end else begin
                readback_r <= readback_r;
            end
        end
    end

    // Drive registered values onto the ports.
    always_comb begin
        hash_q  = hash_r;
        tx_data = tx_data_r;
        cmd_err = cmd_err_r;
    end

endmodule

// File: tb/tb_fnv1a_hash_ctrl.sv
// Self-checking bench for fnv1a_hash_ctrl against a plain-arithmetic FNV-1a model.
module tb_fnv1a_hash_ctrl;

    localparam logic [31:0] OB    = 32'h811C9DC5;
    localparam logic [31:0] PRIME = 32'h01000193;

    logic        clk;
    logic        rst_n;
    logic        rx_start;
    logic        rx_stop;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_req;
    logic [7:0]  tx_data;
    logic        busy;
    logic        cmd_err;
    logic [31:0] hash_q;

    int n_cmp;
    int n_err;

    // Reference model state
    logic [31:0] m_hash;
    logic [31:0] m_rb;
    int          m_ptr;

    fnv1a_hash_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_start (rx_start),
        .rx_stop  (rx_stop),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .tx_req   (tx_req),
        .tx_data  (tx_data),
        .busy     (busy),
        .cmd_err  (cmd_err),
        .hash_q   (hash_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] fnv_step(input logic [31:0] h, input logic [7:0] b);
        logic [31:0] x;
        x = h ^ {24'h000000, b};
        return x * PRIME;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        rx_start = 1'b1;
        @(negedge clk);
        rx_start = 1'b0;
    endtask

    task automatic pulse_stop();
        rx_stop = 1'b1;
        @(negedge clk);
        rx_stop = 1'b0;
    endtask

    // Present a byte, wait for rx_ready, let one edge accept it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("rx_ready_seen", {31'd0, rx_ready}, 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Count busy cycles until the hash step completes.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("busy_clear", {31'd0, busy}, 32'd0);
    endtask

    // Full command transaction: START, command byte, STOP.
    task automatic do_cmd(input logic [7:0] c);
        pulse_start();
        send_byte(c);
        pulse_stop();
        if (c == 8'h01) m_hash = OB;
        if (c == 8'h03) begin
            m_rb  = m_hash;
            m_ptr = 0;
        end
    endtask

    task automatic read_chk();
        logic [31:0] sh;
        tx_req = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
        sh = m_rb >> (24 - 8 * m_ptr);
        check_eq("tx_data", {24'd0, tx_data}, {24'd0, sh[7:0]});
        m_ptr = (m_ptr + 1) % 4;
    endtask

    task automatic feed_one(input logic [7:0] b, output int cyc);
        send_byte(b);
        m_hash = fnv_step(m_hash, b);
        wait_done(cyc);
        check_eq("hash_after_byte", hash_q, m_hash);
    endtask

    logic [7:0] foobar [6];
    int cyc;
    int n;

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; rx_start = 1'b0; rx_stop = 1'b0; rx_valid = 1'b0;
        rx_data = 8'h00; tx_req = 1'b0;
        m_hash = OB; m_rb = OB; m_ptr = 0;
        foobar[0] = 8'h66; foobar[1] = 8'h6F; foobar[2] = 8'h6F;
        foobar[3] = 8'h62; foobar[4] = 8'h61; foobar[5] = 8'h72;

        // Reset values
        @(negedge clk);
        check_eq("rst_hash", hash_q, OB);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_ready", {31'd0, rx_ready}, 32'd0);
        check_eq("rst_tx", {24'd0, tx_data}, 32'd0);
        check_eq("rst_err", {31'd0, cmd_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty-string digest
        do_cmd(8'h03);
        for (int i = 0; i < 4; i++) read_chk();

        // Single byte "a"
        do_cmd(8'h01);
        pulse_start();
        send_byte(8'h02);
        feed_one(8'h61, cyc);
        check_eq("busy_cycles_a", cyc, 32'd7);
        pulse_stop();
        check_eq("hash_a", hash_q, 32'hE40C292C);
        do_cmd(8'h03);
        for (int i = 0; i < 4; i++) read_chk();

        // "foobar" with rx_valid held high throughout
        do_cmd(8'h01);
        pulse_start();
        send_byte(8'h02);
        for (int i = 0; i < 6; i++) begin
            rx_data  = foobar[i];
            rx_valid = 1'b1;
            n = 0;
            while (!rx_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (i > 0) check_eq("ready_low_cycles", n, 32'd7);
            @(negedge clk);
            m_hash = fnv_step(m_hash, foobar[i]);
        end
        rx_valid = 1'b0;
        wait_done(cyc);
        pulse_stop();
        check_eq("hash_foobar", hash_q, 32'hBF9CF968);
        do_cmd(8'h03);
        for (int i = 0; i < 4; i++) read_chk();

        // STOP on the 3rd MUL cycle of the last byte
        do_cmd(8'h01);
        pulse_start();
        send_byte(8'h02);
        feed_one(8'h5A, cyc);
        send_byte(8'hC3);
        m_hash = fnv_step(m_hash, 8'hC3);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        pulse_stop();
        wait_done(cyc);
        check_eq("hash_stop_mid", hash_q, m_hash);
        check_eq("idle_after_stop", {31'd0, rx_ready}, 32'd0);

        // Randomized transactions
        for (int t = 0; t < 20; t++) begin
            int len;
            if ($urandom_range(0, 2) == 0) do_cmd(8'h01);
            len = $urandom_range(0, 4);
            pulse_start();
            send_byte(8'h02);
            for (int k = 0; k < len; k++) begin
                logic [7:0] b;
                b = 8'($urandom_range(0, 255));
                send_byte(b);
                m_hash = fnv_step(m_hash, b);
                if (k == 0) read_chk();
                wait_done(cyc);
            end
            pulse_stop();
            check_eq("rand_hash", hash_q, m_hash);
            if ($urandom_range(0, 1) == 1) begin
                do_cmd(8'h03);
                n = $urandom_range(1, 5);
                for (int r = 0; r < n; r++) read_chk();
            end
        end

        // tx_req in the same cycle as a LATCH accept: old digest first
        pulse_start();
        rx_data  = 8'h03;
        rx_valid = 1'b1;
        tx_req   = 1'b1;
        begin
            logic [31:0] sh;
            sh = m_rb >> (24 - 8 * m_ptr);
            @(negedge clk);
            rx_valid = 1'b0;
            tx_req   = 1'b0;
            check_eq("tx_vs_latch", {24'd0, tx_data}, {24'd0, sh[7:0]});
        end
        m_rb  = m_hash;
        m_ptr = 0;
        pulse_stop();
        read_chk();
        read_chk();

        // Unknown command: sticky error, bytes drained, hash untouched
        pulse_start();
        send_byte(8'h7E);
        check_eq("cmd_err_set", {31'd0, cmd_err}, 32'd1);
        check_eq("drain_ready", {31'd0, rx_ready}, 32'd1);
        send_byte(8'h55);
        send_byte(8'h02);
        check_eq("drain_busy", {31'd0, busy}, 32'd0);
        check_eq("hash_unchanged", hash_q, m_hash);
        pulse_stop();
        check_eq("idle_after_drain", {31'd0, rx_ready}, 32'd0);
        do_cmd(8'h01);
        check_eq("cmd_err_sticky", {31'd0, cmd_err}, 32'd1);

        // Async reset in the middle of a multiply
        pulse_start();
        send_byte(8'h02);
        send_byte(8'hA5);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_hash", hash_q, OB);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_rst_ready", {31'd0, rx_ready}, 32'd0);
        check_eq("mid_rst_tx", {24'd0, tx_data}, 32'd0);
        check_eq("mid_rst_err", {31'd0, cmd_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_hash = OB; m_rb = OB; m_ptr = 0;
        @(negedge clk);
        check_eq("post_rst_hash", hash_q, OB);
        do_cmd(8'h03);
        for (int i = 0; i < 5; i++) read_chk();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
